// File: rtl/sobel_window_gen.sv
// sobel_window_gen: turns a raster stream of 8-bit grey pixels into a stream of
// 3x3 windows. Two line buffers hold the previous two lines. Two column registers
// plus the incoming column form the window, which goes out through one output
// register with zero-bubble back-pressure.
module sobel_window_gen #(
   parameter int unsigned IMG_X_SIZE = 100,
   parameter int unsigned IMG_Y_SIZE = 100
) (
   input  logic        csi_clkrst_clk,
   input  logic        csi_clkrst_reset,
   input  logic [7:0]  asi_sink1_data,
   input  logic        asi_sink1_startofpacket,
   input  logic        asi_sink1_endofpacket,
   input  logic        asi_sink1_valid,
   output logic        asi_sink1_ready,
   input  logic        aso_source1_ready,
   output logic [71:0] aso_source1_data,
   output logic        aso_source1_startofpacket,
   output logic        aso_source1_endofpacket,
   output logic        aso_source1_valid,
   output logic        frame_error
);

   localparam int unsigned XW = $clog2(IMG_X_SIZE);
   localparam int unsigned YW = $clog2(IMG_Y_SIZE);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_X_SIZE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_Y_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1
   } state_t;

   state_t        state, state_nx;
   logic [XW-1:0] x, x_nx, pix_x;
   logic [YW-1:0] y, y_nx;
   logic          accept, pix_we, emit, emit_sop, emit_eop, err;

   // lb1 holds line y-1 and lb2 holds line y-2, both indexed by column.
   logic [7:0]    lb1 [IMG_X_SIZE];
   logic [7:0]    lb2 [IMG_X_SIZE];
   // Columns x-2 and x-1 of the window, packed as {top, mid, bottom}.
   logic [23:0]   col1, col2;
   logic [23:0]   col_new;
   logic [71:0]   window;

   assign asi_sink1_ready = !aso_source1_valid || aso_source1_ready;
   assign accept          = asi_sink1_valid && asi_sink1_ready && !csi_clkrst_reset;

   // The incoming pixel completes column x: the two older lines come from the line buffers.
   assign col_new = {lb2[pix_x], lb1[pix_x], asi_sink1_data};
   assign window  = {col1[23:16], col2[23:16], col_new[23:16],
                     col1[15:8],  col2[15:8],  col_new[15:8],
                     col1[7:0],   col2[7:0],   col_new[7:0]};

   // Frame FSM: decides pixel position, window emission and framing errors.
   always_comb begin
      state_nx = state;
      x_nx     = x;
      y_nx     = y;
      pix_x    = x;
      pix_we   = 1'b0;
      emit     = 1'b0;
      emit_sop = 1'b0;
      emit_eop = 1'b0;
      err      = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept && asi_sink1_startofpacket) begin
               pix_we   = 1'b1;
               pix_x    = '0;
               x_nx     = XW'(1);
               y_nx     = '0;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (asi_sink1_startofpacket) begin
                  // Restart: the abandoned frame's pixels are never used again.
                  err    = 1'b1;
                  pix_we = 1'b1;
                  pix_x  = '0;
                  x_nx   = XW'(1);
                  y_nx   = '0;
               end else if (x == X_LAST && y == Y_LAST) begin
                  pix_we   = 1'b1;
                  emit     = 1'b1;
                  emit_sop = (x == XW'(2)) && (y == YW'(2));
                  emit_eop = 1'b1;
                  err      = !asi_sink1_endofpacket;
                  x_nx     = '0;
                  y_nx     = '0;
                  state_nx = S_IDLE;
               end else if (asi_sink1_endofpacket) begin
                  err      = 1'b1;
                  x_nx     = '0;
                  y_nx     = '0;
                  state_nx = S_IDLE;
               end else begin
                  pix_we   = 1'b1;
                  emit     = (x >= XW'(2)) && (y >= YW'(2));
                  emit_sop = (x == XW'(2)) && (y == YW'(2));
                  if (x == X_LAST) begin
                     x_nx = '0;
                     y_nx = y + YW'(1);
                  end else begin
                     x_nx = x + XW'(1);
                  end
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
            x_nx     = '0;
            y_nx     = '0;
         end
      endcase
   end

   // State and position counters.
   always_ff @(posedge csi_clkrst_clk) begin
      if (csi_clkrst_reset) begin
         state <= S_IDLE;
         x     <= '0;
         y     <= '0;
      end else begin
         state <= state_nx;
         x     <= x_nx;
         y     <= y_nx;
      end
   end

   // Output register: loads only when empty or draining, holds while stalled.
   always_ff @(posedge csi_clkrst_clk) begin
      if (csi_clkrst_reset) begin
         aso_source1_valid         <= 1'b0;
         aso_source1_startofpacket <= 1'b0;
         aso_source1_endofpacket   <= 1'b0;
         aso_source1_data          <= '0;
         frame_error               <= 1'b0;
      end else begin
         frame_error <= err;
         if (asi_sink1_ready) begin
            aso_source1_valid         <= emit;
            aso_source1_startofpacket <= emit_sop;
            aso_source1_endofpacket   <= emit_eop;
            if (emit) begin
               aso_source1_data <= window;
            end
         end
      end
   end

   // Pixel storage: line buffers shift down one line per column, window columns shift left.
   always_ff @(posedge csi_clkrst_clk) begin
      if (pix_we) begin
         lb1[pix_x] <= asi_sink1_data;
         lb2[pix_x] <= lb1[pix_x];
         col1       <= col2;
         col2       <= col_new;
      end
   end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter IMG_X_SIZE, default 100, pixels per line (minimum 3).
REQ-002 SHALL have parameter IMG_Y_SIZE, default 100, lines per frame (minimum 3).
REQ-003 csi_clkrst_clk  in  1  sole clock; all logic on rising edge.
REQ-004 csi_clkrst_reset  in  1  reset, synchronous, active-high.
REQ-005 asi_sink1_data  in  8  raster-order grey pixel.
REQ-006 asi_sink1_startofpacket  in  1  first pixel of frame.
REQ-007 asi_sink1_endofpacket  in  1  last pixel of frame.
REQ-008 asi_sink1_valid  in  1  sink data valid.
REQ-009 asi_sink1_ready  out  1  block accepts sink beat this cycle.
REQ-010 aso_source1_ready  in  1  downstream accepts window.
REQ-011 aso_source1_data  out  72  3x3 window {p00,p01,p02,p10,p11,p12,p20,p21,p22}; p00 in [71:64] is top-left, p22 in [7:0] is bottom-right; row 0 is oldest line.
REQ-012 aso_source1_startofpacket  out  1  first window of frame.
REQ-013 aso_source1_endofpacket  out  1  last window of frame.
REQ-014 aso_source1_valid  out  1  window valid.
REQ-015 frame_error  out  1  one-cycle pulse on framing violation.

Function
REQ-016 Sink beat accepted when asi_sink1_valid && asi_sink1_ready; source beat transferred when aso_source1_valid && aso_source1_ready.
REQ-017 asi_sink1_ready SHALL equal !aso_source1_valid || aso_source1_ready (single output register, zero-bubble).
REQ-018 State machine: IDLE (wait for SOP), RUN (collect frame); any other encoding returns to IDLE.
REQ-019 IDLE: accepted beat without SOP discarded, no output; accepted beat with SOP is pixel (0,0), go RUN.
REQ-020 Column counter x (0..IMG_X_SIZE-1) and row counter y (0..IMG_Y_SIZE-1) advance per accepted pixel; x wraps to 0 and increments y at end of line.
REQ-021 Two line buffers of IMG_X_SIZE x 8 bits hold lines y-1 and y-2; three 3-deep column shift registers hold the current window.
REQ-022 Accepted pixel at (x,y) with x>=2 and y>=2 SHALL load the output register with the window whose bottom-right is (x,y), valid asserted the following cycle (latency 1).
REQ-023 Output SOP SHALL be 1 only for window at (2,2); output EOP only for window at (IMG_X_SIZE-1, IMG_Y_SIZE-1).
REQ-024 Windows per frame SHALL be exactly (IMG_X_SIZE-2)*(IMG_Y_SIZE-2); no window for x<2 or y<2.
REQ-025 Frame end is positional: accepted pixel at (IMG_X_SIZE-1, IMG_Y_SIZE-1) returns FSM to IDLE and clears counters, regardless of EOP flag.
REQ-026 EOP missing at last position: window still emitted with output EOP=1, frame_error pulses.
REQ-027 EOP on accepted pixel before last position: pixel dropped, no further windows, FSM to IDLE, frame_error pulses; a pending output window still drains normally.
REQ-028 SOP on accepted pixel in RUN: frame_error pulses, current frame abandoned, pixel taken as (0,0) of new frame, FSM stays RUN.
REQ-029 While aso_source1_valid && !aso_source1_ready, output data/SOP/EOP SHALL hold stable and no sink beat is accepted.
REQ-030 Line buffer/shift register contents need no reset; emitted windows use only pixels of the current frame.

Reset
REQ-031 On csi_clkrst_reset=1 at a clock edge: FSM IDLE, x=y=0, aso_source1_valid=0, aso_source1_startofpacket=0, aso_source1_endofpacket=0, frame_error=0, aso_source1_data=0.
REQ-032 During reset asi_sink1_ready SHALL be 1 (output register empty) but accepted beats are ignored; mid-frame reset discards the frame, next window only after a new SOP.

Verification
REQ-033 IMG_X_SIZE=IMG_Y_SIZE=4, pixel=4y+x, ready=1 -> 4 windows; first {0,1,2,4,5,6,8,9,10} with SOP, one cycle after pixel 10 accepted; last {5,6,7,9,10,11,13,14,15} with EOP.
REQ-034 Same frame, aso_source1_ready low 3 cycles while window {1,2,3,5,6,7,9,10,11} valid -> data stable, asi_sink1_ready=0 those cycles, no window lost or duplicated.
REQ-035 Beats 7,7,7 without SOP then valid 4x4 frame -> leading beats discarded, output identical to REQ-033.
REQ-036 4x4 frame with EOP on pixel 9 -> one frame_error pulse, zero windows, next SOP frame yields REQ-033 output.
REQ-037 Reset asserted after pixel 12 of 4x4 frame -> valid=0 next cycle, then fresh frame gives exactly 4 correct windows.
REQ-038 Default 100x100 random frame with random valid/ready -> 9604 windows, each matching reference model, SOP/EOP once each.
